// File: rtl/adder_pkg.sv
// ============================================================================
//  Module   : adder_pkg
//  Brief    : Shared sizes, kernel-size encodings and round-count helper for
//             the convolution adder-tree/accumulator stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int NUM_GROUPS = 36;
    localparam int LANES      = 128;
    localparam int PROD_W     = 16;
    localparam int TREE_W     = 23;
    localparam int PSUM_W     = 24;
    localparam int GROUP_W    = LANES * PROD_W;

    typedef enum logic [3:0] {
        WS_3X3 = 4'd0,
        WS_5X5 = 4'd1,
        WS_7X7 = 4'd2
    } wsize_e;

    // Number of weight rounds accumulated before a result is emitted.
    // Unknown kernel sizes fall back to the 3x3 behaviour.
    function automatic logic [2:0] num_rounds(input logic [3:0] wsize, input logic stride);
        logic [2:0] r;
        case (wsize)
            WS_5X5:  r = stride ? 3'd1 : 3'd2;
            WS_7X7:  r = stride ? 3'd2 : 3'd4;
            default: r = 3'd1;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_tree128.sv
// ============================================================================
//  Module   : adder_tree128
//  Brief    : Combinational 128-to-1 signed reduction of 16-bit products into
//             a 23-bit sum (wide enough that it can never overflow).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_tree128
    import adder_pkg::*;
(
    input  logic [GROUP_W-1:0]       lanes,
    output logic signed [TREE_W-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int l = 0; l < LANES; l++) begin
            sum = sum + TREE_W'($signed(lanes[l*PROD_W +: PROD_W]));
        end
    end

endmodule

`default_nettype wire

// File: rtl/adder.sv
// ============================================================================
//  Module   : adder
//  Brief    : Pipelined adder tree + multi-round 24-bit accumulator placed
//             after the multiplier array. Define ADDER_SAT_EN to saturate the
//             accumulate step; otherwise it wraps modulo 2^24.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder
    import adder_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   wsize,
    input  logic                         stride,
    input  logic [2:0]                   wround,
    input  logic [NUM_GROUPS*GROUP_W-1:0] MUL_results,
    input  logic                         MUL_DATA_valid,
    output logic                         Psum_valid,
    output logic [NUM_GROUPS*PSUM_W-1:0] Psum
);

    // Stage 0: captured beat
    logic [NUM_GROUPS*GROUP_W-1:0] beat_q, beat_d;
    logic                          s0_valid_q, s0_valid_d;
    logic [3:0]                    s0_wsize_q, s0_wsize_d;
    logic                          s0_stride_q, s0_stride_d;
    logic [2:0]                    s0_wround_q, s0_wround_d;

    // Stage 1: registered tree sums
    logic [NUM_GROUPS-1:0][TREE_W-1:0] tree_sum;
    logic [NUM_GROUPS-1:0][TREE_W-1:0] tree_q, tree_d;
    logic                              s1_valid_q, s1_valid_d;
    logic [3:0]                        s1_wsize_q, s1_wsize_d;
    logic                              s1_stride_q, s1_stride_d;
    logic [2:0]                        s1_wround_q, s1_wround_d;

    // Stage 2: accumulators and output
    logic [NUM_GROUPS-1:0][PSUM_W-1:0] acc_q, acc_d;
    logic [NUM_GROUPS-1:0][PSUM_W-1:0] psum_q, psum_d;
    logic                              psum_valid_q, psum_valid_d;

    generate
        for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_tree
            adder_tree128 u_tree (
                .lanes (beat_q[g*GROUP_W +: GROUP_W]),
                .sum   (tree_sum[g])
            );
        end
    endgenerate

    // Data registers only move on a valid beat, so idle cycles change nothing.
    always_comb begin
        s0_valid_d  = MUL_DATA_valid;
        beat_d      = MUL_DATA_valid ? MUL_results : beat_q;
        s0_wsize_d  = MUL_DATA_valid ? wsize       : s0_wsize_q;
        s0_stride_d = MUL_DATA_valid ? stride      : s0_stride_q;
        s0_wround_d = MUL_DATA_valid ? wround      : s0_wround_q;

        s1_valid_d  = s0_valid_q;
        tree_d      = s0_valid_q ? tree_sum    : tree_q;
        s1_wsize_d  = s0_valid_q ? s0_wsize_q  : s1_wsize_q;
        s1_stride_d = s0_valid_q ? s0_stride_q : s1_stride_q;
        s1_wround_d = s0_valid_q ? s0_wround_q : s1_wround_q;
    end

    always_comb begin
        logic [PSUM_W-1:0] base;
        logic [PSUM_W:0]   sum;
        base         = '0;
        sum          = '0;
        acc_d        = acc_q;
        psum_d       = psum_q;
        psum_valid_d = 1'b0;
        if (s1_valid_q) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                base = (s1_wround_q == 3'd0) ? '0 : acc_q[g];
                sum  = {base[PSUM_W-1], base}
                     + {{(PSUM_W+1-TREE_W){tree_q[g][TREE_W-1]}}, tree_q[g]};
`ifdef ADDER_SAT_EN
                if (sum[PSUM_W] != sum[PSUM_W-1]) begin
                    acc_d[g] = sum[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}}
                                           : {1'b0, {(PSUM_W-1){1'b1}}};
                end else begin
                    acc_d[g] = sum[PSUM_W-1:0];
                end
`else
                acc_d[g] = sum[PSUM_W-1:0];
`endif
            end
            if (s1_wround_q >= (num_rounds(s1_wsize_q, s1_stride_q) - 3'd1)) begin
                psum_d       = acc_d;
                psum_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q       <= '0;
            s0_valid_q   <= 1'b0;
            s0_wsize_q   <= '0;
            s0_stride_q  <= 1'b0;
            s0_wround_q  <= '0;
            tree_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_wsize_q   <= '0;
            s1_stride_q  <= 1'b0;
            s1_wround_q  <= '0;
            acc_q        <= '0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
        end else begin
            beat_q       <= beat_d;
            s0_valid_q   <= s0_valid_d;
            s0_wsize_q   <= s0_wsize_d;
            s0_stride_q  <= s0_stride_d;
            s0_wround_q  <= s0_wround_d;
            tree_q       <= tree_d;
            s1_valid_q   <= s1_valid_d;
            s1_wsize_q   <= s1_wsize_d;
            s1_stride_q  <= s1_stride_d;
            s1_wround_q  <= s1_wround_d;
            acc_q        <= acc_d;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
        end
    end

    assign Psum_valid = psum_valid_q;
    assign Psum       = psum_q;

endmodule

`default_nettype wire

// File: tb/tb_adder.sv
// ============================================================================
//  Module   : tb_adder
//  Brief    : Directed, table-driven self-checking bench for adder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder;
    import adder_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [3:0]                    wsize;
    logic                          stride;
    logic [2:0]                    wround;
    logic [NUM_GROUPS*GROUP_W-1:0] mul_results;
    logic                          mul_valid;
    logic                          psum_valid;
    logic [NUM_GROUPS*PSUM_W-1:0]  psum;

    int n_cmp = 0;
    int n_err = 0;

    adder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wsize          (wsize),
        .stride         (stride),
        .wround         (wround),
        .MUL_results    (mul_results),
        .MUL_DATA_valid (mul_valid),
        .Psum_valid     (psum_valid),
        .Psum           (psum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ws;
        logic       st;
        int         nb;     // back-to-back beats, wround 0..nb-1
        int         v;      // lane value for group 0
        int         s;      // per-group increment of lane value
        int         exp0;   // expected Psum of group 0
        int         estep;  // per-group increment of expected Psum
    } vec_t;

    vec_t tv[10];

    task automatic drive(input logic vld, input logic [3:0] ws, input logic st,
                         input logic [2:0] wr, input int v, input int s);
        mul_valid = vld;
        wsize     = ws;
        stride    = st;
        wround    = wr;
        for (int g = 0; g < NUM_GROUPS; g++)
            for (int l = 0; l < LANES; l++)
                mul_results[g*GROUP_W + l*PROD_W +: PROD_W] = 16'(v + g*s);
    endtask

    task automatic check_valid(input logic exp, input string tag);
        n_cmp++;
        if (psum_valid !== exp) begin
            n_err++;
            $display("FAIL %s: Psum_valid=%b expected %b", tag, psum_valid, exp);
        end
    endtask

    task automatic check_psum(input int e0, input int es, input string tag);
        int bad;
        int got;
        int bad_got;
        bad     = -1;
        bad_got = 0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            got = int'($signed(psum[g*PSUM_W +: PSUM_W]));
            if (got != e0 + g*es && bad < 0) begin
                bad     = g;
                bad_got = got;
            end
        end
        n_cmp++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: Psum[%0d]=%0d expected %0d", tag, bad, bad_got, e0 + bad*es);
        end
    endtask

    // Beats on consecutive cycles, then idle; exactly one pulse two edges
    // after the sampling edge of the final beat, Psum held afterwards.
    task automatic run_seq(input vec_t t, input string tag);
        for (int c = 0; c <= t.nb + 2; c++) begin
            if (c < t.nb) drive(1'b1, t.ws, t.st, 3'(c), t.v, t.s);
            else          drive(1'b0, t.ws, t.st, 3'(c), 16'h5A5A, 0);
            @(posedge clk);
            #1;
            check_valid(c == t.nb + 1, tag);
            if (c >= t.nb + 1) check_psum(t.exp0, t.estep, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int av[4];
        vec_t rv;

        tv[0] = '{4'd0, 1'b0, 1, 1,      0, 128,      0};
        tv[1] = '{4'd1, 1'b0, 2, 1,      0, 256,      0};
        tv[2] = '{4'd2, 1'b0, 4, -1,     0, -512,     0};
        tv[3] = '{4'd2, 1'b1, 2, 2,      0, 512,      0};
`ifdef ADDER_SAT_EN
        tv[4] = '{4'd2, 1'b0, 4, 32767,  0, 8388607,  0};
        tv[8] = '{4'd2, 1'b0, 4, -32768, 0, -8388608, 0};
`else
        tv[4] = '{4'd2, 1'b0, 4, 32767,  0, -512,     0};
        tv[8] = '{4'd2, 1'b0, 4, -32768, 0, 0,        0};
`endif
        tv[5] = '{4'd0, 1'b0, 1, 3,      1, 384,      128};
        tv[6] = '{4'd1, 1'b1, 1, -5,     0, -640,     0};
        tv[7] = '{4'd5, 1'b0, 1, -32768, 0, -4194304, 0};
        tv[9] = '{4'd1, 1'b0, 2, 100,    2, 25600,    512};

        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 3'd0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_valid(1'b0, "reset_valid");
        check_psum(0, 0, "reset_psum");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_seq(tv[i], $sformatf("vec%0d", i));

        // Last beat immediately followed by a fresh round-0 beat.
        av = '{2, 2, 1, 1};
        for (int c = 0; c <= 6; c++) begin
            if (c < 4) drive(1'b1, 4'd2, 1'b1, 3'(c % 2), av[c], 0);
            else       drive(1'b0, 4'd2, 1'b1, 3'd0, 0, 0);
            @(posedge clk);
            #1;
            check_valid(c == 3 || c == 5, "restart_valid");
            if (c == 3 || c == 4) check_psum(512, 0, "restart_psum_a");
            if (c >= 5)           check_psum(256, 0, "restart_psum_b");
        end

        // Idle gap between rounds with junk on the data inputs.
        for (int c = 0; c <= 5; c++) begin
            if (c == 0)      drive(1'b1, 4'd1, 1'b0, 3'd0, 3, 0);
            else if (c == 2) drive(1'b1, 4'd1, 1'b0, 3'd1, 3, 0);
            else             drive(1'b0, 4'd0, 1'b0, 3'd1, 16'h5A5A, 0);
            @(posedge clk);
            #1;
            check_valid(c == 4, "gap_valid");
            if (c < 4) check_psum(256, 0, "gap_hold");
            else       check_psum(768, 0, "gap_psum");
        end

        // Reset in the middle of a 7x7 accumulation.
        drive(1'b1, 4'd2, 1'b0, 3'd0, 1, 0);
        @(posedge clk);
        #1;
        drive(1'b1, 4'd2, 1'b0, 3'd1, 1, 0);
        @(posedge clk);
        #1;
        drive(1'b0, 4'd2, 1'b0, 3'd2, 1, 0);
        rst_n = 1'b0;
        #2;
        check_valid(1'b0, "midreset_valid");
        check_psum(0, 0, "midreset_psum");
        repeat (2) @(posedge clk);
        #1;
        check_valid(1'b0, "midreset_valid_hold");
        rst_n = 1'b1;
        rv = '{4'd0, 1'b0, 1, 7, 0, 896, 0};
        run_seq(rv, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
